// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/redirect bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = datapath side, slave = controller side.
interface pipe_hazard_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              id_load_use;
    logic              ex_br_miss;
    logic [ADDR_W-1:0] ex_br_target;
    logic              ex_mdu_start;
    logic              mdu_done;
    logic              mem_excp;
    logic [ADDR_W-1:0] mem_excp_pc;
    logic              sb_empty;
    logic [3:0]        stall;
    logic [3:0]        flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mdu_cancel;

    modport master (
        output id_load_use,
        output ex_br_miss,
        output ex_br_target,
        output ex_mdu_start,
        output mdu_done,
        output mem_excp,
        output mem_excp_pc,
        output sb_empty,
        input  stall,
        input  flush,
        input  redirect_valid,
        input  redirect_pc,
        input  mdu_cancel
    );

    modport slave (
        input  id_load_use,
        input  ex_br_miss,
        input  ex_br_target,
        input  ex_mdu_start,
        input  mdu_done,
        input  mem_excp,
        input  mem_excp_pc,
        input  sb_empty,
        output stall,
        output flush,
        output redirect_valid,
        output redirect_pc,
        output mdu_cancel
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for IF_ID..MEM_WB plus front-end redirect.
// Sequences exception drain, post-redirect flush hold and MDU stalls.
module pipe_hazard_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int FLUSH_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN,
        MDU_WAIT,
        EXCP_DRAIN,
        HOLD
    } state_t;

    localparam logic [2:0] HOLD_INIT = 3'(FLUSH_HOLD);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic [ADDR_W-1:0] excp_pc;
    logic [ADDR_W-1:0] excp_pc_nxt;
    logic [ADDR_W-1:0] rpc;
    logic [ADDR_W-1:0] rpc_nxt;
    logic              rv;
    logic              rv_nxt;
    logic              cancel;
    logic              cancel_nxt;
    logic [3:0]        stall;
    logic [3:0]        flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            cnt     <= 3'd0;
            excp_pc <= '0;
            rpc     <= '0;
            rv      <= 1'b0;
            cancel  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            excp_pc <= excp_pc_nxt;
            rpc     <= rpc_nxt;
            rv      <= rv_nxt;
            cancel  <= cancel_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        excp_pc_nxt = excp_pc;
        rpc_nxt     = rpc;
        rv_nxt      = 1'b0;
        cancel_nxt  = 1'b0;
        stall       = 4'b0000;
        flush       = 4'b0000;

        unique case (state)
            RUN, HOLD: begin
                if (hz.mem_excp) begin
                    flush       = 4'b0111;
                    cancel_nxt  = hz.ex_mdu_start;
                    excp_pc_nxt = hz.mem_excp_pc;
                    state_nxt   = EXCP_DRAIN;
                end else if (state == HOLD) begin
                    flush   = 4'b0001;
                    cnt_nxt = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state_nxt = RUN;
                    end
                end else if (hz.ex_br_miss) begin
                    flush     = 4'b0011;
                    rv_nxt    = 1'b1;
                    rpc_nxt   = hz.ex_br_target;
                    cnt_nxt   = HOLD_INIT;
                    state_nxt = HOLD;
                end else if (hz.ex_mdu_start && !hz.mdu_done) begin
                    stall     = 4'b0011;
                    state_nxt = MDU_WAIT;
                end else if (hz.id_load_use) begin
                    stall = 4'b0001;
                    flush = 4'b0010;
                end
            end
            MDU_WAIT: begin
                if (hz.mem_excp) begin
                    flush       = 4'b0111;
                    cancel_nxt  = 1'b1;
                    excp_pc_nxt = hz.mem_excp_pc;
                    state_nxt   = EXCP_DRAIN;
                end else if (!hz.mdu_done) begin
                    stall = 4'b0011;
                end else begin
                    state_nxt = RUN;
                end
            end
            EXCP_DRAIN: begin
                // Younger stages stay dead until the redirect lands.
                flush = 4'b0111;
                if (!hz.sb_empty) begin
                    stall = 4'b0001;
                end else begin
                    rv_nxt    = 1'b1;
                    rpc_nxt   = excp_pc;
                    cnt_nxt   = HOLD_INIT;
                    state_nxt = HOLD;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (rst) begin
            stall = 4'b0000;
            flush = 4'b1111;
        end
    end

    assign hz.stall          = stall;
    assign hz.flush          = flush;
    assign hz.redirect_valid = rv;
    assign hz.redirect_pc    = rpc;
    assign hz.mdu_cancel     = cancel;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle stimulus and expected
// outputs are queued together, then compared as each cycle completes.
module tb_pipe_hazard_ctrl;

    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.ADDR_W(AW)) hz ();

    pipe_hazard_ctrl #(
        .ADDR_W    (AW),
        .FLUSH_HOLD(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    typedef struct packed {
        logic          rst;
        logic          lu;
        logic          br;
        logic          ms;
        logic          md;
        logic          ex;
        logic          sb;
        logic [AW-1:0] tgt;
        logic [AW-1:0] epc;
    } stim_t;

    typedef struct packed {
        logic [3:0]    stall;
        logic [3:0]    flush;
        logic          rv;
        logic          cancel;
        logic [AW-1:0] pc;
    } obs_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic stim_t idle();
        stim_t s;
        s    = '0;
        s.sb = 1'b1;
        return s;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%b fl=%b rv=%b cn=%b pc=%h",
                         o.stall, o.flush, o.rv, o.cancel, o.pc);
    endfunction

    task automatic push(input stim_t s, input logic [3:0] st,
                        input logic [3:0] fl, input logic rv,
                        input logic cn, input logic [AW-1:0] pc);
        obs_t e;
        e.stall  = st;
        e.flush  = fl;
        e.rv     = rv;
        e.cancel = cn;
        e.pc     = rv ? pc : '0;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic run_cycle(output obs_t o);
        stim_t s;
        s = stim_q.pop_front();
        @(negedge clk);
        rst             = s.rst;
        hz.id_load_use  = s.lu;
        hz.ex_br_miss   = s.br;
        hz.ex_br_target = s.tgt;
        hz.ex_mdu_start = s.ms;
        hz.mdu_done     = s.md;
        hz.mem_excp     = s.ex;
        hz.mem_excp_pc  = s.epc;
        hz.sb_empty     = s.sb;
        #1;
        o.stall  = hz.stall;
        o.flush  = hz.flush;
        o.rv     = hz.redirect_valid;
        o.cancel = hz.mdu_cancel;
        o.pc     = hz.redirect_valid ? hz.redirect_pc : '0;
    endtask

    task automatic test_reset();
        stim_t s;
        obs_t  o;
        obs_t  e;
        int    n = 0;
        @(posedge clk);
        s = idle();
        s.rst = 1'b1;
        push(s, 4'b0000, 4'b1111, 1'b0, 1'b0, '0);
        push(s, 4'b0000, 4'b1111, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        while (stim_q.size() > 0) begin
            run_cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset cyc%0d got %s want %s", n, fmt(o), fmt(e));
            end
            n++;
        end
    endtask

    task automatic test_load_use();
        stim_t s;
        obs_t  o;
        obs_t  e;
        int    n = 0;
        s = idle();
        s.lu = 1'b1;
        push(s, 4'b0001, 4'b0010, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        while (stim_q.size() > 0) begin
            run_cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_use cyc%0d got %s want %s", n, fmt(o), fmt(e));
            end
            n++;
        end
    endtask

    task automatic test_branch();
        stim_t s;
        obs_t  o;
        obs_t  e;
        int    n = 0;
        s = idle();
        s.br  = 1'b1;
        s.tgt = 32'h1c00_0100;
        push(s, 4'b0000, 4'b0011, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h1c00_0100);
        push(idle(), 4'b0000, 4'b0001, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        while (stim_q.size() > 0) begin
            run_cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch cyc%0d got %s want %s", n, fmt(o), fmt(e));
            end
            n++;
        end
    endtask

    task automatic test_mdu();
        stim_t s;
        obs_t  o;
        obs_t  e;
        int    n = 0;
        s = idle();
        s.ms = 1'b1;
        push(s, 4'b0011, 4'b0000, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            push(idle(), 4'b0011, 4'b0000, 1'b0, 1'b0, '0);
        end
        s = idle();
        s.md = 1'b1;
        push(s, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        // start and done together: no stall at all
        s = idle();
        s.ms = 1'b1;
        s.md = 1'b1;
        push(s, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        while (stim_q.size() > 0) begin
            run_cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mdu cyc%0d got %s want %s", n, fmt(o), fmt(e));
            end
            n++;
        end
    endtask

    task automatic test_excp_mdu();
        stim_t s;
        obs_t  o;
        obs_t  e;
        int    n = 0;
        s = idle();
        s.ms = 1'b1;
        push(s, 4'b0011, 4'b0000, 1'b0, 1'b0, '0);
        push(idle(), 4'b0011, 4'b0000, 1'b0, 1'b0, '0);
        s = idle();
        s.ex  = 1'b1;
        s.epc = 32'h1c00_8000;
        s.sb  = 1'b0;
        push(s, 4'b0000, 4'b0111, 1'b0, 1'b0, '0);
        s = idle();
        s.sb = 1'b0;
        push(s, 4'b0001, 4'b0111, 1'b0, 1'b1, '0);
        push(s, 4'b0001, 4'b0111, 1'b0, 1'b0, '0);
        push(s, 4'b0001, 4'b0111, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0111, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h1c00_8000);
        push(idle(), 4'b0000, 4'b0001, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        while (stim_q.size() > 0) begin
            run_cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL excp_mdu cyc%0d got %s want %s", n, fmt(o), fmt(e));
            end
            n++;
        end
    endtask

    task automatic test_simultaneous();
        stim_t s;
        obs_t  o;
        obs_t  e;
        int    n = 0;
        s = idle();
        s.ex  = 1'b1;
        s.br  = 1'b1;
        s.ms  = 1'b1;
        s.tgt = 32'hdead_0000;
        s.epc = 32'h1c00_2000;
        push(s, 4'b0000, 4'b0111, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0111, 1'b0, 1'b1, '0);
        push(idle(), 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h1c00_2000);
        push(idle(), 4'b0000, 4'b0001, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        while (stim_q.size() > 0) begin
            run_cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL simultaneous cyc%0d got %s want %s", n, fmt(o), fmt(e));
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        obs_t  o;
        obs_t  e;
        int    n = 0;
        s = idle();
        s.br  = 1'b1;
        s.tgt = 32'h1c00_0200;
        push(s, 4'b0000, 4'b0011, 1'b0, 1'b0, '0);
        s = idle();
        s.ex  = 1'b1;
        s.epc = 32'h1c00_a000;
        push(s, 4'b0000, 4'b0111, 1'b1, 1'b0, 32'h1c00_0200);
        push(idle(), 4'b0000, 4'b0111, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h1c00_a000);
        push(idle(), 4'b0000, 4'b0001, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        while (stim_q.size() > 0) begin
            run_cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got %s want %s", n, fmt(o), fmt(e));
            end
            n++;
        end
    endtask

    task automatic test_reset_mid();
        stim_t s;
        obs_t  o;
        obs_t  e;
        int    n = 0;
        s = idle();
        s.rst = 1'b1;
        s.br  = 1'b1;
        s.tgt = 32'h1c00_0300;
        push(s, 4'b0000, 4'b1111, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        push(idle(), 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        while (stim_q.size() > 0) begin
            run_cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid cyc%0d got %s want %s", n, fmt(o), fmt(e));
            end
            n++;
        end
    endtask

    initial begin
        hz.id_load_use  = 1'b0;
        hz.ex_br_miss   = 1'b0;
        hz.ex_br_target = '0;
        hz.ex_mdu_start = 1'b0;
        hz.mdu_done     = 1'b0;
        hz.mem_excp     = 1'b0;
        hz.mem_excp_pc  = '0;
        hz.sb_empty     = 1'b1;
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_excp_mdu();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
